b01_sink: RTL and testbench
===========================

B01_SINK -- requirements
Module: b01_sink

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter WIDTH, default 8, bits per packed word; SHALL be 2..15.
REQ-003 clock  input  1  single clock; all state SHALL update on posedge clock only.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on posedge clock.
REQ-005 en  input  1  sample enable; outp/overflw are ignored when en=0.
REQ-006 outp  input  1  serial result bit from the b01 FSM.
REQ-007 overflw  input  1  overflow/frame-end flag from the b01 FSM.
REQ-008 out_valid  output  1  head FIFO entry available.
REQ-009 out_ready  input  1  consumer accepts head entry when out_valid=1.
REQ-010 out_data  output  WIDTH  packed bits; first sampled bit in bit 0.
REQ-011 out_len  output  4  number of valid bits in out_data, 1..WIDTH.
REQ-012 out_ovf  output  1  1 = word closed by overflw.
REQ-013 fifo_level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-014 ovf_count  output  8  sampled overflw=1 events, saturating.
REQ-015 drop_count  output  8  words lost to FIFO full, saturating.

Function
REQ-016 Sample: posedge with en=1 and reset=0; outp SHALL be written to packer bit position bit_cnt.
REQ-017 bit_cnt SHALL count 0..WIDTH-1, advance by 1 per sample, unchanged when en=0.
REQ-018 Word close: on a sample with bit_cnt=WIDTH-1 or overflw=1; the closed word SHALL include the bit sampled in that cycle.
REQ-019 Closed word SHALL be {data, len=bit_cnt+1, ovf=overflw}; unused upper data bits SHALL be 0.
REQ-020 On close, bit_cnt SHALL return to 0 and packer bits SHALL clear to 0 in the same edge.
REQ-021 Closed word SHALL be visible at FIFO head (out_valid=1 if FIFO was empty) the cycle after the closing edge; latency 1.
REQ-022 Pop: out_valid=1 and out_ready=1 at a posedge; head SHALL advance at that edge.
REQ-023 out_data/out_len/out_ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 out_valid SHALL not depend combinationally on out_ready.
REQ-025 Full: push with fifo_level=DEPTH and no pop in same edge SHALL drop the word and increment drop_count.
REQ-026 Push and pop in same edge with FIFO full SHALL accept the push; level unchanged, no drop.
REQ-027 Push and pop in same edge with FIFO non-empty SHALL leave fifo_level unchanged.
REQ-028 Pop with out_valid=0 SHALL be ignored; fifo_level SHALL never underflow.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; ordering SHALL be strict FIFO.
REQ-030 ovf_count SHALL increment on each sample with overflw=1, holding at 255.
REQ-031 drop_count SHALL hold at 255; no wrap.
REQ-032 overflw=1 with en=0 SHALL have no effect on any state.

Reset
REQ-033 reset=1 at posedge SHALL set bit_cnt=0, packer=0, FIFO empty, out_valid=0, fifo_level=0, ovf_count=0, drop_count=0.
REQ-034 While reset=1, out_data/out_len/out_ovf SHALL read 0.
REQ-035 reset SHALL override sample and pop in the same edge; a partial word SHALL be discarded, not pushed.
REQ-036 First sample after reset SHALL land in bit 0.

Verification
REQ-037 Reset, en=1, outp=1,0,1,1,0,0,1,0, overflw=0, out_ready=1 -> one word out_data=0x4D, out_len=8, out_ovf=0, one cycle after 8th sample.
REQ-038 3 samples outp=1,1,1 with overflw=1 on 3rd -> out_data=0x07, out_len=3, out_ovf=1, ovf_count=1; next word starts at bit 0.
REQ-039 out_ready=0, push 5 full words (DEPTH=4) -> fifo_level=4, drop_count=1; draining yields words 1-4 in order, 5th absent.
REQ-040 FIFO full, out_ready=1 in the edge a 5th word closes -> no drop, fifo_level stays 4, word 5 emerges after words 2-4.
REQ-041 Reset asserted after 5 samples -> no word emitted, all counters 0; next 8 samples form a fresh full word.
REQ-042 260 samples with overflw=1, out_ready=1 -> ovf_count=255; en=0 with overflw=1 -> no count, no word.

Source files
------------

// File: rtl/b01_sink.sv
// Serial-to-word packer for the b01 FSM result stream, feeding a small FIFO.
// Words close when they are full or when overflw is sampled.
module b01_sink #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       outp,
    input  logic                       overflw,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [3:0]                 out_len,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 ovf_count,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = WIDTH + 5;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] pack_q, pack_d;
    logic [WIDTH-1:0] word_bits;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             valid_q, valid_d;
    logic [7:0]       ovf_cnt_q, ovf_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             close_word;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic             show;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    head;

    // Packer view including the bit being sampled this cycle.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pack
            assign word_bits[gi] = (bit_cnt_q == 4'(gi)) ? outp : pack_q[gi];
        end
    endgenerate

    assign close_word = en && ((bit_cnt_q == 4'(WIDTH - 1)) || overflw);
    assign pop        = valid_q && out_ready;
    assign full       = (level_q == FULL_LVL);
    assign push       = close_word && (!full || pop);
    assign drop       = close_word && full && !pop;
    assign wr_entry   = {overflw, bit_cnt_q + 4'd1, word_bits};
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        pack_d     = pack_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_cnt_d  = ovf_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (en) begin
            if (close_word) begin
                bit_cnt_d = 4'd0;
                pack_d    = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                pack_d    = word_bits;
            end
        end

        if (en && overflw && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        valid_d = (level_d != '0);
    end

    // Storage has no reset; contents are only observed behind valid_q.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt_q  <= 4'd0;
            pack_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            ovf_cnt_q  <= 8'd0;
            drop_cnt_q <= 8'd0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            pack_q     <= pack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            ovf_cnt_q  <= ovf_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Head fields read as zero whenever nothing is presented or reset is held.
    assign show       = valid_q && !reset;
    assign out_valid  = valid_q;
    assign out_data   = show ? head[WIDTH-1:0] : '0;
    assign out_len    = show ? head[WIDTH+3:WIDTH] : 4'd0;
    assign out_ovf    = show & head[EW-1];
    assign fifo_level = level_q;
    assign ovf_count  = ovf_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_b01_sink.sv
// Randomized and directed bench for b01_sink against a queue-based model of
// the packer and FIFO.
module tb_b01_sink;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             outp = 1'b0;
    logic             overflw = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_len;
    logic             out_ovf;
    logic [2:0]       fifo_level;
    logic [7:0]       ovf_count;
    logic [7:0]       drop_count;

    b01_sink #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .outp       (outp),
        .overflw    (overflw),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_len    (out_len),
        .out_ovf    (out_ovf),
        .fifo_level (fifo_level),
        .ovf_count  (ovf_count),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int data;
        int len;
        bit ovf;
    } word_t;

    word_t m_q[$];
    int    m_val = 0;
    int    m_cnt = 0;
    int    m_ovfc = 0;
    int    m_dropc = 0;
    int    checks = 0;
    int    failures = 0;
    bit    chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge: words are built arithmetically and queued.
    task automatic model_edge(input bit r, input bit e, input bit o, input bit v, input bit rd);
        word_t w;
        bit    do_push;
        if (r) begin
            m_q.delete();
            m_val = 0; m_cnt = 0; m_ovfc = 0; m_dropc = 0;
            return;
        end
        do_push = 1'b0;
        if (e) begin
            m_val = m_val + (int'(o) << m_cnt);
            if (v && m_ovfc < 255) m_ovfc++;
            if (m_cnt == WIDTH - 1 || v) begin
                w.data = m_val; w.len = m_cnt + 1; w.ovf = v;
                do_push = 1'b1;
                m_val = 0; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (m_q.size() > 0 && rd) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else if (m_dropc < 255) m_dropc++;
        end
    endtask

    // Inputs are applied just after an edge and held through the next one.
    task automatic step(input bit r, input bit e, input bit o, input bit v, input bit rd);
        reset = r; en = e; outp = o; overflw = v; out_ready = rd;
        @(posedge clock);
        model_edge(r, e, o, v, rd);
        #1;
    endtask

    task automatic send_word(input int data, input int len, input bit ovf,
                             input bit rdy, input bit rdy_last);
        for (int i = 0; i < len; i++) begin
            step(1'b0, 1'b1, 1'(data >> i), ovf && (i == len - 1),
                 (i == len - 1) ? rdy_last : rdy);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("valid", 32'(out_valid), 32'(m_q.size() != 0));
            chk("level", 32'(fifo_level), 32'(m_q.size()));
            chk("ovf_count", 32'(ovf_count), 32'(m_ovfc));
            chk("drop_count", 32'(drop_count), 32'(m_dropc));
            if (reset) begin
                chk("rst_data", 32'(out_data), 32'd0);
                chk("rst_len", 32'(out_len), 32'd0);
                chk("rst_ovf", 32'(out_ovf), 32'd0);
            end else if (m_q.size() != 0) begin
                chk("data", 32'(out_data), 32'(m_q[0].data));
                chk("len", 32'(out_len), 32'(m_q[0].len));
                chk("ovf", 32'(out_ovf), 32'(m_q[0].ovf));
            end
        end
    end

    initial begin
        bit r, e, o, v, rd;
        int pat;
        pat = 32'h4D;

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_level", 32'(fifo_level), 32'd0);

        // Eight serial bits 1,0,1,1,0,0,1,0 pack to 0x4D.
        send_word(pat, 8, 1'b0, 1'b1, 1'b1);
        chk("r37_valid", 32'(out_valid), 32'd1);
        chk("r37_data", 32'(out_data), 32'h4D);
        chk("r37_len", 32'(out_len), 32'd8);
        chk("r37_ovf", 32'(out_ovf), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Short word closed by overflw, then next word starts at bit 0.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(7, 3, 1'b1, 1'b1, 1'b1);
        chk("r38_data", 32'(out_data), 32'h07);
        chk("r38_len", 32'(out_len), 32'd3);
        chk("r38_ovf", 32'(out_ovf), 32'd1);
        chk("r38_ovfc", 32'(ovf_count), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("r38_next_data", 32'(out_data), 32'h01);
        chk("r38_next_len", 32'(out_len), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Five words into a stalled FIFO: the fifth is dropped.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) send_word(8'h11 * k, 8, 1'b0, 1'b0, 1'b0);
        chk("r39_level", 32'(fifo_level), 32'd4);
        chk("r39_drop", 32'(drop_count), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("r39_order", 32'(out_data), 32'(8'h11 * k));
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("r39_empty", 32'(out_valid), 32'd0);

        // Full FIFO with a pop on the closing edge accepts the fifth word.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) send_word(8'h11 * k, 8, 1'b0, 1'b0, 1'b0);
        send_word(8'h55, 8, 1'b0, 1'b0, 1'b1);
        chk("r40_level", 32'(fifo_level), 32'd4);
        chk("r40_drop", 32'(drop_count), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            chk("r40_order", 32'(out_data), 32'(8'h11 * k));
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Reset mid-word discards the partial word.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(5'h1F, 5, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("r41_valid", 32'(out_valid), 32'd0);
        chk("r41_level", 32'(fifo_level), 32'd0);
        send_word(8'hA5, 8, 1'b0, 1'b1, 1'b1);
        chk("r41_data", 32'(out_data), 32'hA5);
        chk("r41_len", 32'(out_len), 32'd8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // ovf_count saturation, then en=0 with overflw has no effect.
        for (int i = 0; i < 260; i++) step(1'b0, 1'b1, i[0], 1'b1, 1'b1);
        chk("r42_ovfc", 32'(ovf_count), 32'd255);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("r42_ovfc_hold", 32'(ovf_count), 32'd255);
        chk("r42_no_word", 32'(out_valid), 32'd0);

        // drop_count saturation under permanent backpressure.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("drop_sat", 32'(drop_count), 32'd255);
        chk("drop_level", 32'(fifo_level), 32'd4);

        // Randomized traffic with bursts of backpressure.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 3) != 0);
            o  = 1'($urandom);
            v  = ($urandom_range(0, 9) == 0);
            rd = ((i / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                     : ($urandom_range(0, 2) != 0);
            step(r, e, o, v, rd);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
